// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
   localparam int          ENTRY_W      = 32 + 32 + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched entries: push/pop/flush, full/empty.
// DEPTH must be a power of 2 (>=2); pointers carry one wrap bit.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 65
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;
   logic         do_push, do_pop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   // Pointer update; flush empties the queue and wins over push/pop.
   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, looks up IM combinationally,
// queues {pc, instr, exc} for decode, handles redirect/halt/flush.
// Optional fetch-exception checking is enabled by defining FETCH_CTRL_EXC_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter int          IM_WORDS   = 4096,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] im_adr,
   input  logic [31:0] im_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_exc,
   output logic        halted
);
   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         push, flush, pop, full, empty, bad_pc;
   fetch_entry_t push_entry, head;

`ifdef FETCH_CTRL_EXC_EN
   localparam logic [31:0] IM_LAST = PC_RESET + 32'(4 * IM_WORDS - 4);
   // After an exception entry is queued, fetching stalls until a redirect.
   logic exc_hold_q, exc_hold_d;
   assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || (pc_q > IM_LAST);
`else
   assign bad_pc = 1'b0;
`endif

   assign im_adr    = pc_q;
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign halted    = (state_q == ST_HALT);
   assign out_pc    = out_valid ? head.pc    : 32'h0;
   assign out_instr = out_valid ? head.instr : 32'h0;
   assign out_exc   = out_valid && head.exc;

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = bad_pc ? 32'h0 : im_instr;
   assign push_entry.exc   = bad_pc;

   // Next state: FSM, PC advance, push/flush decisions.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      push    = 1'b0;
      flush   = 1'b0;
`ifdef FETCH_CTRL_EXC_EN
      exc_hold_d = exc_hold_q;
`endif
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
               pc_d  = redirect_pc;
`ifdef FETCH_CTRL_EXC_EN
               exc_hold_d = 1'b0;
`endif
            end else if (!halt_req && !full
`ifdef FETCH_CTRL_EXC_EN
                         && !exc_hold_q
`endif
                        ) begin
               push = 1'b1;
               if (bad_pc) begin
`ifdef FETCH_CTRL_EXC_EN
                  exc_hold_d = 1'b1;
`endif
               end else begin
                  pc_d = pc_q + 32'd4;
               end
            end
            if (halt_req) state_d = ST_HALT;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase
   end

   // State, PC and exception-stall registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_BOOT;
         pc_q    <= PC_RESET;
`ifdef FETCH_CTRL_EXC_EN
         exc_hold_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
`ifdef FETCH_CTRL_EXC_EN
         exc_hold_q <= exc_hold_d;
`endif
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push),
      .din_i   (push_entry),
      .pop_i   (pop),
      .flush_i (flush),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] im_adr, im_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt_req = 1'b0;
   logic        out_valid, out_ready, out_exc, halted;
   logic [31:0] out_pc, out_instr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // IM model: word index relative to 0x3000, 12-bit truncated.
   function automatic logic [31:0] im_word(input logic [31:0] adr);
      logic [31:0] off;
      off = adr - 32'h3000;
      return 32'hA000_0000 | {20'h0, off[13:2]};
   endfunction

   assign im_instr = im_word(im_adr);

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .im_adr(im_adr), .im_instr(im_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_exc(out_exc), .halted(halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      do_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (im_adr !== 32'h3000) begin failures++; $display("FAIL reset_adr got=%h exp=00003000", im_adr); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
      checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_exc !== 1'b0) begin
         failures++; $display("FAIL reset_outs pc=%h instr=%h exc=%0b exp=0", out_pc, out_instr, out_exc); end
   endtask

   task automatic test_stream();
      int n;
      out_ready = 1'b1;
      do_reset();
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (n !== 2) begin failures++; $display("FAIL stream_latency got=%0d exp=2", n); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4*k) || out_instr !== im_word(32'h3000 + 32'(4*k))) begin
            failures++;
            $display("FAIL stream_%0d valid=%0b pc=%h instr=%h exp_pc=%h exp_instr=%h", k, out_valid, out_pc,
                     out_instr, 32'h3000 + 32'(4*k), im_word(32'h3000 + 32'(4*k)));
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got [3];
      int n, cnt;
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000) begin
         failures++; $display("FAIL hold_head valid=%0b pc=%h exp=1/00003000", out_valid, out_pc); end
      checks++; if (im_adr !== 32'h3008) begin failures++; $display("FAIL hold_adr got=%h exp=00003008", im_adr); end
      out_ready = 1'b1;
      n = 0; cnt = 0;
      while (cnt < 3 && n < 10) begin
         if (out_valid === 1'b1) begin got[cnt] = out_pc; cnt++; end
         tick(); n++;
      end
      checks++; if (cnt !== 3) begin failures++; $display("FAIL drain_count got=%0d exp=3", cnt); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (k < cnt && got[k] !== 32'h3000 + 32'(4*k)) begin
            failures++; $display("FAIL drain_order_%0d got=%h exp=%h", k, got[k], 32'h3000 + 32'(4*k)); end
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h3040; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || im_adr !== 32'h3040) begin
         failures++; $display("FAIL redir_flush valid=%0b adr=%h exp=0/00003040", out_valid, im_adr); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3040 || out_instr !== im_word(32'h3040)) begin
         failures++; $display("FAIL redir_first valid=%0b pc=%h instr=%h exp=1/00003040/%h", out_valid, out_pc,
                              out_instr, im_word(32'h3040)); end
   endtask

   task automatic test_halt();
      int n, bad;
      out_ready = 1'b1;
      do_reset();
      n = 0;
      while (im_adr !== 32'h300C && n < 10) begin tick(); n++; end
      checks++; if (im_adr !== 32'h300C) begin failures++; $display("FAIL halt_reach adr=%h exp=0000300c", im_adr); end
      halt_req = 1'b1; out_ready = 1'b0;
      tick();
      halt_req = 1'b0;
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0b exp=1", halted); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3008) begin
         failures++; $display("FAIL halt_queued valid=%0b pc=%h exp=1/00003008", out_valid, out_pc); end
      redirect_valid = 1'b1; redirect_pc = 32'h3040; out_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      checks++; if (im_adr !== 32'h300C) begin failures++; $display("FAIL halt_redir_ignored adr=%h exp=0000300c", im_adr); end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid === 1'b1 && out_pc >= 32'h300C) bad++;
         tick();
      end
      checks++; if (bad !== 0 || out_valid !== 1'b0 || halted !== 1'b1) begin
         failures++; $display("FAIL halt_no_fetch late_entries=%0d valid=%0b halted=%0b exp=0/0/1", bad, out_valid, halted); end
   endtask

`ifdef FETCH_CTRL_EXC_EN
   task automatic test_exc();
      logic [31:0] bad_tgt [2];
      bad_tgt[0] = 32'h3002; bad_tgt[1] = 32'h7000;
      out_ready = 1'b0;
      do_reset();
      tick(); tick();
      for (int k = 0; k < 2; k++) begin
         redirect_valid = 1'b1; redirect_pc = bad_tgt[k]; out_ready = 1'b0;
         tick();
         redirect_valid = 1'b0;
         tick();
         checks++; if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_instr !== 32'h0 || out_pc !== bad_tgt[k]) begin
            failures++; $display("FAIL exc_entry_%0d valid=%0b exc=%0b instr=%h pc=%h exp=1/1/0/%h", k, out_valid,
                                 out_exc, out_instr, out_pc, bad_tgt[k]); end
         out_ready = 1'b1;
         tick(); tick();
         checks++; if (out_valid !== 1'b0 || im_adr !== bad_tgt[k]) begin
            failures++; $display("FAIL exc_stall_%0d valid=%0b adr=%h exp=0/%h", k, out_valid, im_adr, bad_tgt[k]); end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h3010;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_exc !== 1'b0 || out_pc !== 32'h3010 || out_instr !== im_word(32'h3010)) begin
         failures++; $display("FAIL exc_resume valid=%0b exc=%0b pc=%h instr=%h exp=1/0/00003010/%h", out_valid,
                              out_exc, out_pc, out_instr, im_word(32'h3010)); end
   endtask
`endif

   task automatic test_reset_mid();
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h3080; reset = 1'b1;
      tick();
      reset = 1'b0; redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || im_adr !== 32'h3000 || halted !== 1'b0) begin
         failures++; $display("FAIL reset_mid valid=%0b adr=%h halted=%0b exp=0/00003000/0", out_valid, im_adr, halted); end
   endtask

   initial begin
      out_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
`ifdef FETCH_CTRL_EXC_EN
      test_exc();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
